// File: rtl/i2c_master_bit_sequencer_if.sv
// Command-side handshake between the I2C master controller and
// the bit sequencer.
interface i2c_master_bit_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       master_ack;
  logic       done;
  logic       rx_ack;
  logic       arb_lost;
  logic       busy;

  modport master (
    output cmd_valid, cmd, master_ack,
    input  cmd_ready, done, rx_ack, arb_lost, busy
  );

  modport slave (
    input  cmd_valid, cmd, master_ack,
    output cmd_ready, done, rx_ack, arb_lost, busy
  );
endinterface

// File: rtl/i2c_master_bit_sequencer.sv
// I2C master bit sequencer: START/WRITE/READ/STOP in quarter-bit phases.
// Optional slave clock stretching in phase C via I2C_CLOCK_STRETCH_EN.
module i2c_master_bit_sequencer #(
  parameter int unsigned QUARTER_DIV = 42
) (
  input  logic clk,
  input  logic rst,
  i2c_master_bit_sequencer_if.slave ctl,
  input  logic shift_out,
  output logic shift_load,
  output logic shift_strobe,
  output logic shift_in,
  output logic scl_out,
  output logic sda_out,
  input  logic scl_in,
  input  logic sda_in
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, BIT, ACK, STOP
  } state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_D = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(QUARTER_DIV - 1);

  state_t      state, state_d;
  logic [1:0]  ph, ph_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bits, bits_d;
  logic        rd, rd_d;
  logic        mack, mack_d;
  logic        scl_d, sda_d, sin_d;
  logic        rx_q, rx_d;
  logic        done_q, done_d;
  logic        arb_q, arb_d;
  logic        hold, last;

`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = (ph == PH_C) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  assign last = (cnt == CNT_LAST) && !hold;

  assign ctl.cmd_ready = (state == IDLE);
  assign ctl.busy      = (state != IDLE);
  assign ctl.done      = done_q;
  assign ctl.arb_lost  = arb_q;
  assign ctl.rx_ack    = rx_q;

  assign shift_load   = (state == LOAD);
  assign shift_strobe = (state == BIT) && (ph == PH_D) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= PH_A;
      cnt      <= '0;
      bits     <= '0;
      rd       <= 1'b0;
      mack     <= 1'b0;
      scl_out  <= 1'b1;
      sda_out  <= 1'b1;
      shift_in <= 1'b0;
      rx_q     <= 1'b1;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
    end else begin
      state    <= state_d;
      ph       <= ph_d;
      cnt      <= cnt_d;
      bits     <= bits_d;
      rd       <= rd_d;
      mack     <= mack_d;
      scl_out  <= scl_d;
      sda_out  <= sda_d;
      shift_in <= sin_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
    end
  end

  always_comb begin
    state_d = state;
    ph_d    = ph;
    cnt_d   = cnt;
    bits_d  = bits;
    rd_d    = rd;
    mack_d  = mack;
    scl_d   = scl_out;
    sda_d   = sda_out;
    sin_d   = shift_in;
    rx_d    = rx_q;
    done_d  = 1'b0;
    arb_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (ctl.cmd_valid) begin
          ph_d   = PH_A;
          cnt_d  = '0;
          bits_d = '0;
          rd_d   = (ctl.cmd == CMD_READ);
          mack_d = ctl.master_ack;
          unique case (ctl.cmd)
            CMD_START: state_d = START;
            CMD_WRITE: state_d = LOAD;
            CMD_READ:  state_d = BIT;
            default:   state_d = STOP;
          endcase
        end
      end
      LOAD: state_d = BIT;
      default: begin
        if (!hold) cnt_d = last ? '0 : cnt + 16'd1;
        if (last) begin
          ph_d = ph + 2'd1;
          if (ph == PH_C) begin
            if (state == BIT) begin
              sin_d = sda_in;
              arb_d = !rd && sda_out && !sda_in;
            end
            if (state == ACK && !rd) rx_d = sda_in;
          end
          if (ph == PH_D) begin
            if (state == BIT && bits != 3'd7) begin
              bits_d = bits + 3'd1;
            end else if (state == BIT) begin
              state_d = ACK;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
    endcase

    if (arb_d) state_d = IDLE;

    // bus levels follow the phase about to run; write data re-samples all of A
    unique case (1'b1)
      arb_d: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      state_d == START: begin
        scl_d = (ph_d == PH_A) ? scl_out : (ph_d != PH_D);
        sda_d = !ph_d[1];
      end
      state_d == STOP: begin
        scl_d = (ph_d != PH_A);
        sda_d = ph_d[1];
      end
      state_d == BIT: begin
        scl_d = ph_d[1];
        if (ph_d == PH_A) sda_d = rd_d ? 1'b1 : shift_out;
      end
      state_d == ACK: begin
        scl_d = ph_d[1];
        if (ph_d == PH_A) sda_d = rd_d ? mack_d : 1'b1;
      end
      default: ;
    endcase
  end

endmodule
